// File: rtl/axi_read_slave_if.sv
// AXI4 read address/data channel bundle shared by a read master and the axi_read_slave responder.
interface axi_read_slave_if #(
  parameter int IDW = 12,
  parameter int AW  = 32,
  parameter int DW  = 64
);
  logic [IDW-1:0] arid;
  logic [AW-1:0]  araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic           arvalid;
  logic           arready;
  logic [IDW-1:0] rid;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_read_slave.sv
// AXI4 read responder: walks FIXED/INCR/WRAP bursts, fetching one beat per FETCH/RESP pair
// from a local memory port and returning it on R with RLAST, ID echo and SLVERR for illegal requests.
module axi_read_slave #(
  parameter int IDW = 12,
  parameter int AW  = 32,
  parameter int DW  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_read_slave_if.slave       s_axi,
  output logic                  mem_en,
  output logic [AW-1:0]         mem_addr,
  input  logic [DW-1:0]         mem_rdata
);
  localparam int         BYTES = DW / 8;
  localparam int         LSB   = $clog2(BYTES);
  localparam logic [2:0] LSB3  = 3'(LSB);
  localparam logic [AW-1:0] BUS_MASK = AW'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

  state_t         state_reg;
  logic [IDW-1:0] id_reg;
  logic [AW-1:0]  addr_reg;
  logic [7:0]     len_reg;
  logic [2:0]     size_reg;
  logic [1:0]     burst_reg;
  logic           err_reg;
  logic [7:0]     beat_reg;
  logic [AW-1:0]  wrap_base_reg;
  logic [AW-1:0]  wrap_mask_reg;

  logic           arready_reg;
  logic [IDW-1:0] rid_reg;
  logic [DW-1:0]  rdata_reg;
  logic [1:0]     rresp_reg;
  logic           rlast_reg;
  logic           rvalid_reg;
  logic           mem_en_reg;
  logic [AW-1:0]  mem_addr_reg;

  assign s_axi.arready = arready_reg;
  assign s_axi.rid     = rid_reg;
  assign s_axi.rdata   = rdata_reg;
  assign s_axi.rresp   = rresp_reg;
  assign s_axi.rlast   = rlast_reg;
  assign s_axi.rvalid  = rvalid_reg;
  assign mem_en        = mem_en_reg;
  assign mem_addr      = mem_addr_reg;

  // Request decode: size mask, wrap container mask and error classification.
  logic [AW-1:0] size_mask_in;
  logic [AW-1:0] total_mask_in;
  logic          wrap_len_ok;
  logic          err_in;

  always_comb begin
    size_mask_in  = (AW'(1) << s_axi.arsize) - AW'(1);
    total_mask_in = ((AW'(s_axi.arlen) + AW'(1)) << s_axi.arsize) - AW'(1);
    wrap_len_ok   = (s_axi.arlen == 8'd1) || (s_axi.arlen == 8'd3) ||
                    (s_axi.arlen == 8'd7) || (s_axi.arlen == 8'd15);
    err_in        = 1'b0;
    if (s_axi.arsize > LSB3)
      err_in = 1'b1;
    if (s_axi.arburst == 2'b11)
      err_in = 1'b1;
    if (s_axi.arburst == 2'b10 && (!wrap_len_ok || (s_axi.araddr & size_mask_in) != '0))
      err_in = 1'b1;
  end

  // Address of the following beat; beat 0 of an INCR burst may be unaligned.
  logic [AW-1:0] step;
  logic [AW-1:0] next_addr;

  always_comb begin
    step = AW'(1) << size_reg;
    case (burst_reg)
      2'b00:   next_addr = addr_reg;
      2'b10:   next_addr = wrap_base_reg |
                           ((addr_reg + step - wrap_base_reg) & wrap_mask_reg);
      default: next_addr = (addr_reg & ~(step - AW'(1))) + step;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      id_reg        <= '0;
      addr_reg      <= '0;
      len_reg       <= '0;
      size_reg      <= '0;
      burst_reg     <= '0;
      err_reg       <= 1'b0;
      beat_reg      <= '0;
      wrap_base_reg <= '0;
      wrap_mask_reg <= '0;
      arready_reg   <= 1'b0;
      rid_reg       <= '0;
      rdata_reg     <= '0;
      rresp_reg     <= 2'b00;
      rlast_reg     <= 1'b0;
      rvalid_reg    <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_addr_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          arready_reg <= 1'b1;
          if (s_axi.arvalid && arready_reg) begin
            arready_reg   <= 1'b0;
            id_reg        <= s_axi.arid;
            addr_reg      <= s_axi.araddr;
            len_reg       <= s_axi.arlen;
            size_reg      <= s_axi.arsize;
            burst_reg     <= s_axi.arburst;
            err_reg       <= err_in;
            beat_reg      <= '0;
            wrap_base_reg <= s_axi.araddr & ~total_mask_in;
            wrap_mask_reg <= total_mask_in;
            mem_en_reg    <= !err_in;
            mem_addr_reg  <= s_axi.araddr & ~BUS_MASK;
            state_reg     <= FETCH;
          end
        end
        FETCH: begin
          // mem_rdata is captured on the edge that closes the mem_en cycle.
          mem_en_reg <= 1'b0;
          rvalid_reg <= 1'b1;
          rid_reg    <= id_reg;
          rdata_reg  <= err_reg ? '0 : mem_rdata;
          rresp_reg  <= err_reg ? 2'b10 : 2'b00;
          rlast_reg  <= (beat_reg == len_reg);
          state_reg  <= RESP;
        end
        RESP: begin
          if (rvalid_reg && s_axi.rready) begin
            rvalid_reg <= 1'b0;
            if (rlast_reg) begin
              rlast_reg   <= 1'b0;
              arready_reg <= 1'b1;
              state_reg   <= IDLE;
            end else begin
              beat_reg     <= beat_reg + 8'd1;
              addr_reg     <= next_addr;
              mem_en_reg   <= !err_reg;
              mem_addr_reg <= next_addr & ~BUS_MASK;
              state_reg    <= FETCH;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_read_slave.sv
// Directed bench for axi_read_slave: a table of bursts with hand-computed beat addresses,
// plus a hand-written mid-burst reset sequence.
module tb_axi_read_slave;
  localparam int IDW = 12;
  localparam int AW  = 32;
  localparam int DW  = 64;

  logic          clk;
  logic          rst;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;

  int n_vec;
  int n_err;
  int hs_cnt;

  axi_read_slave_if #(.IDW(IDW), .AW(AW), .DW(DW)) bus ();

  axi_read_slave #(.IDW(IDW), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axi     (bus),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mdata(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a};
  endfunction

  // Memory contents are a fixed function of the address; garbage when not strobed.
  assign mem_rdata = mem_en ? mdata(mem_addr) : 64'hDEAD_BEEF_DEAD_BEEF;

  always @(posedge clk) if (bus.rvalid && bus.rready) hs_cnt <= hs_cnt + 1;

  typedef struct {
    string             name;
    logic [1:0]        burst;
    logic [31:0]       addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [11:0]       id;
    logic              err;
    int                stall_beat;
    int                stall_n;
    logic [3:0][31:0]  ea;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(input string name, input logic [1:0] burst, input logic [31:0] addr,
                              input logic [7:0] len, input logic [2:0] size, input logic [11:0] id,
                              input logic err, input int sb, input int sn,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3);
    vec_t v;
    v.name = name; v.burst = burst; v.addr = addr; v.len = len; v.size = size;
    v.id = id; v.err = err; v.stall_beat = sb; v.stall_n = sn;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_arready();
    int to;
    to = 0;
    while (bus.arready !== 1'b1 && to < 20) begin
      @(negedge clk);
      to++;
    end
    chk("arready_wait", {63'd0, bus.arready}, 64'd1);
  endtask

  task automatic run_burst(input vec_t v);
    logic [63:0] exp_d;
    int          hs0;
    wait_arready();
    hs0 = hs_cnt;
    bus.arvalid = 1'b1;
    bus.arid    = v.id;
    bus.araddr  = v.addr;
    bus.arlen   = v.len;
    bus.arsize  = v.size;
    bus.arburst = v.burst;
    @(negedge clk);
    bus.arvalid = 1'b0;
    chk({v.name, ".arready_busy"}, {63'd0, bus.arready}, 64'd0);
    for (int b = 0; b <= int'(v.len); b++) begin
      chk({v.name, ".mem_en"}, {63'd0, mem_en}, {63'd0, !v.err});
      if (!v.err) chk({v.name, ".mem_addr"}, {32'd0, mem_addr}, {32'd0, v.ea[b]});
      chk({v.name, ".rvalid_fetch"}, {63'd0, bus.rvalid}, 64'd0);
      if (b == v.stall_beat && v.stall_n > 0) bus.rready = 1'b0;
      @(negedge clk);
      exp_d = v.err ? 64'd0 : mdata(v.ea[b]);
      chk({v.name, ".rvalid"}, {63'd0, bus.rvalid}, 64'd1);
      chk({v.name, ".rid"}, {52'd0, bus.rid}, {52'd0, v.id});
      chk({v.name, ".rresp"}, {62'd0, bus.rresp}, v.err ? 64'd2 : 64'd0);
      chk({v.name, ".rdata"}, bus.rdata, exp_d);
      chk({v.name, ".rlast"}, {63'd0, bus.rlast}, {63'd0, b == int'(v.len)});
      if (b == v.stall_beat && v.stall_n > 0) begin
        for (int s = 1; s < v.stall_n; s++) begin
          @(negedge clk);
          chk({v.name, ".stall_rvalid"}, {63'd0, bus.rvalid}, 64'd1);
          chk({v.name, ".stall_rdata"}, bus.rdata, exp_d);
          chk({v.name, ".stall_rlast"}, {63'd0, bus.rlast}, {63'd0, b == int'(v.len)});
        end
        bus.rready = 1'b1;
      end
      @(negedge clk);
    end
    chk({v.name, ".arready_done"}, {63'd0, bus.arready}, 64'd1);
    chk({v.name, ".rvalid_done"}, {63'd0, bus.rvalid}, 64'd0);
    chk({v.name, ".handshakes"}, 64'(hs_cnt - hs0), 64'(int'(v.len) + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0; n_err = 0; hs_cnt = 0;
    vecs[0]  = mk("incr_single", 2'b01, 32'h104, 8'd0, 3'd2, 12'h05A, 1'b0, -1, 0, 32'h100, 0, 0, 0);
    vecs[1]  = mk("incr_stall",  2'b01, 32'h100, 8'd3, 3'd3, 12'h123, 1'b0, 1, 3,
                  32'h100, 32'h108, 32'h110, 32'h118);
    vecs[2]  = mk("wrap4",       2'b10, 32'h118, 8'd3, 3'd3, 12'h7A1, 1'b0, -1, 0,
                  32'h118, 32'h100, 32'h108, 32'h110);
    vecs[3]  = mk("fixed3",      2'b00, 32'h040, 8'd2, 3'd3, 12'h3C4, 1'b0, -1, 0,
                  32'h040, 32'h040, 32'h040, 0);
    vecs[4]  = mk("err_size",    2'b01, 32'h200, 8'd1, 3'd4, 12'h011, 1'b1, -1, 0, 0, 0, 0, 0);
    vecs[5]  = mk("err_burst",   2'b11, 32'h300, 8'd0, 3'd3, 12'h022, 1'b1, -1, 0, 0, 0, 0, 0);
    vecs[6]  = mk("err_wraplen", 2'b10, 32'h100, 8'd2, 3'd3, 12'h033, 1'b1, -1, 0, 0, 0, 0, 0);
    vecs[7]  = mk("incr_byte",   2'b01, 32'h007, 8'd1, 3'd0, 12'h044, 1'b0, -1, 0, 32'h000, 32'h008, 0, 0);
    vecs[8]  = mk("incr_rollover", 2'b01, 32'hFFFF_FFF8, 8'd1, 3'd3, 12'hFFF, 1'b0, -1, 0,
                  32'hFFFF_FFF8, 32'h0, 0, 0);
    vecs[9]  = mk("err_wrapalign", 2'b10, 32'h104, 8'd1, 3'd3, 12'h055, 1'b1, -1, 0, 0, 0, 0, 0);
    vecs[10] = mk("wrap2_w32",   2'b10, 32'h10C, 8'd1, 3'd2, 12'h066, 1'b0, -1, 0, 32'h108, 32'h108, 0, 0);

    rst = 1'b1;
    bus.arvalid = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0;
    bus.arsize = '0; bus.arburst = '0; bus.rready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.arready", {63'd0, bus.arready}, 64'd0);
    chk("rst.rvalid", {63'd0, bus.rvalid}, 64'd0);
    chk("rst.rlast", {63'd0, bus.rlast}, 64'd0);
    chk("rst.rid", {52'd0, bus.rid}, 64'd0);
    chk("rst.rdata", bus.rdata, 64'd0);
    chk("rst.rresp", {62'd0, bus.rresp}, 64'd0);
    chk("rst.mem_en", {63'd0, mem_en}, 64'd0);
    chk("rst.mem_addr", {32'd0, mem_addr}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.arready_rise", {63'd0, bus.arready}, 64'd1);

    for (int i = 0; i < 11; i++) begin
      run_burst(vecs[i]);
      $display("burst %0d %s done, beats=%0d", i, vecs[i].name, int'(vecs[i].len) + 1);
    end

    // Mid-burst reset: 8-beat INCR, reset while beat 1 is held on R.
    wait_arready();
    bus.arvalid = 1'b1; bus.arid = 12'h0AB; bus.araddr = 32'h200;
    bus.arlen = 8'd7; bus.arsize = 3'd3; bus.arburst = 2'b01;
    @(negedge clk);
    bus.arvalid = 1'b0;
    @(negedge clk);
    chk("mrst.beat0_rdata", bus.rdata, mdata(32'h200));
    @(negedge clk);
    chk("mrst.beat1_addr", {32'd0, mem_addr}, {32'd0, 32'h208});
    bus.rready = 1'b0;
    @(negedge clk);
    chk("mrst.beat1_rvalid", {63'd0, bus.rvalid}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst.rvalid", {63'd0, bus.rvalid}, 64'd0);
    chk("mrst.mem_en", {63'd0, mem_en}, 64'd0);
    chk("mrst.arready", {63'd0, bus.arready}, 64'd0);
    bus.rready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst.arready_rise", {63'd0, bus.arready}, 64'd1);
    chk("mrst.no_beats", {63'd0, bus.rvalid}, 64'd0);
    run_burst(vecs[0]);
    $display("mid-burst reset sequence done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
